// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: acquisition sequencer between the ADC sample stream and
// the SDRAM write port. Arms on request, fills a circular buffer with
// pre-trigger history, detects a level/edge trigger, captures a fixed
// post-trigger count and reports the trigger address.
// Optional feature macro: AUTO_TRIGGER_EN (forces a trigger after cfg_auto
// clk cycles spent in WAIT; cfg_auto is ignored when undefined).
module adc_capture_ctrl #(
  parameter int DW = 10,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          arm,
  input  logic          abort,
  input  logic [DW-1:0] cfg_level,
  input  logic          cfg_edge,
  input  logic [AW-1:0] cfg_pre,
  input  logic [AW-1:0] cfg_post,
  input  logic [23:0]   cfg_auto,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_addr,
  output logic          overrun,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_WAIT  = 3'd2,
    S_POST  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] lat_level;
  logic          lat_edge;
  logic [AW-1:0] lat_pre;
  logic [AW-1:0] lat_post;

  logic [AW-1:0] wptr;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_inc;
  logic [DW-1:0] prev;
  logic          prev_valid;

  logic          arm_ok;
  logic          cap_phase;
  logic          slot_free;
  logic          capture;
  logic          drop;
  logic          edge_hit;
  logic          auto_fire;
  logic          trig_hit;

  assign arm_ok    = arm && !abort && (state_q == S_IDLE || state_q == S_DONE);
  assign slot_free = !mem_valid || mem_ready;
  assign capture   = cap_phase && smp_valid && slot_free && !abort;
  assign drop      = cap_phase && smp_valid && !slot_free && !abort;
  assign cnt_inc   = cnt + AW'(1);
  assign edge_hit  = prev_valid &&
                     (lat_edge ? (prev > lat_level && smp_data <= lat_level)
                               : (prev < lat_level && smp_data >= lat_level));
  assign trig_hit  = capture && (state_q == S_WAIT) && (edge_hit || auto_fire);

`ifdef AUTO_TRIGGER_EN
  logic [23:0] lat_auto;
  logic [23:0] auto_cnt;

  // WAIT dwell counter: zero outside WAIT, saturates at the latched timeout
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lat_auto <= '0;
      auto_cnt <= '0;
    end else begin
      if (arm_ok) lat_auto <= cfg_auto;
      if (state_q != S_WAIT)       auto_cnt <= '0;
      else if (auto_cnt != lat_auto) auto_cnt <= auto_cnt + 24'd1;
    end
  end

  assign auto_fire = (lat_auto != '0) && (auto_cnt == lat_auto);
`else
  logic cfg_auto_unused;
  assign cfg_auto_unused = ^cfg_auto;
  assign auto_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort overrides everything, including a same-cycle arm
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm) state_d = S_PRE;
        S_PRE: begin
          if (lat_pre == '0)                         state_d = S_WAIT;
          else if (capture && cnt_inc == lat_pre)    state_d = S_WAIT;
        end
        S_WAIT:  if (trig_hit) state_d = (lat_post == '0) ? S_FLUSH : S_POST;
        S_POST:  if (capture && cnt_inc == lat_post) state_d = S_FLUSH;
        S_FLUSH: if (slot_free) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs and capture window
  always_comb begin
    state     = state_q;
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
    cap_phase = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  end

  // Config latch, pointer, counters, previous sample, trigger address, overrun
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      lat_level  <= '0;
      lat_edge   <= 1'b0;
      lat_pre    <= '0;
      lat_post   <= '0;
      wptr       <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      trig_addr  <= '0;
      overrun    <= 1'b0;
    end else if (arm_ok) begin
      lat_level  <= cfg_level;
      lat_edge   <= cfg_edge;
      lat_pre    <= cfg_pre;
      lat_post   <= cfg_post;
      wptr       <= '0;
      cnt        <= '0;
      prev_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (drop) overrun <= 1'b1;
      if (capture) begin
        wptr       <= wptr + AW'(1);
        prev       <= smp_data;
        prev_valid <= 1'b1;
        if (trig_hit) begin
          trig_addr <= wptr;
          cnt       <= '0;
        end else if (state_q != S_WAIT) begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  // Write request register; a pending request is held until accepted
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else if (capture) begin
      mem_valid <= 1'b1;
      mem_addr  <= wptr;
      mem_data  <= smp_data;
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

endmodule
